tcp_server_conn_ctrl: RTL and testbench
=======================================

// Module: tcp_server_conn_ctrl
// PURPOSE
//  Passive-open TCP connection controller (server side): sequences LISTEN -> SYN-ACK -> ESTABLISHED.
//  Consumes parsed RX segment headers, issues SYN-ACK header requests to the TX segment builder.
//  Negotiates MSS with the team's standard rule, retransmits SYN-ACK on timeout, aborts after N retries.
//  Sits between the RX header parser and the TX header builder of the TCP server core.
// PARAMETERS
//  SYNACK_TIMEOUT  1000  cycles in WAIT_ACK before a SYN-ACK retransmit (>=2)
//  MAX_RETRIES     3     SYN-ACK retransmits allowed before abort (>=0)
//  DEFAULT_MSS     536   MSS ceiling and fallback value
// PORTS
//  clk          in   1   single clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  isn          in   32  initial send sequence number, sampled when a SYN is accepted
//  rx_valid     in   1   RX header valid
//  rx_ready     out  1   controller accepts header; consumed when rx_valid & rx_ready
//  rx_syn       in   1   SYN flag
//  rx_ack       in   1   ACK flag
//  rx_fin       in   1   FIN flag
//  rx_rst       in   1   RST flag
//  rx_seq       in   32  segment sequence number
//  rx_ack_num   in   32  segment acknowledgement number
//  rx_mss       in   16  MSS option value; 0 = option absent
//  tx_valid     out  1   SYN-ACK request valid; fields held stable until tx_ready
//  tx_ready     in   1   TX builder accepts request
//  tx_syn       out  1   SYN flag of request (1 whenever tx_valid)
//  tx_ack       out  1   ACK flag of request (1 whenever tx_valid)
//  tx_seq       out  32  = ISS
//  tx_ack_num   out  32  = IRS + 1
//  tx_mss       out  16  negotiated MSS
//  mss          out  16  negotiated MSS of current connection; DEFAULT_MSS in LISTEN
//  established  out  1   high in ESTABLISHED
//  abort        out  1   one-cycle pulse when retries exhausted
//  state        out  2   0 LISTEN, 1 SEND_SYNACK, 2 WAIT_ACK, 3 ESTABLISHED
// BEHAVIOUR
//  Reset: state LISTEN; tx_valid/established/abort 0; tx_* fields 0; mss DEFAULT_MSS; timer/retry 0.
//   Reset mid-handshake: tx_valid drops at the reset edge, no partial request is retained.
//  rx_ready = 1 in LISTEN, WAIT_ACK, ESTABLISHED; 0 in SEND_SYNACK. Non-matching segments are consumed and dropped.
//  MSS rule: mss_n = (rx_mss < DEFAULT_MSS && rx_mss != 0) ? rx_mss : DEFAULT_MSS (16-bit unsigned compare).
//  LISTEN: accepted seg with syn=1, ack=0, rst=0 -> latch IRS=rx_seq, ISS=isn, mss=mss_n, retry=0 -> SEND_SYNACK.
//  SEND_SYNACK: tx_valid=1 from the cycle after entry; on tx_valid & tx_ready -> WAIT_ACK, timer=0, tx_valid=0 next cycle.
//  WAIT_ACK (timer +1 per cycle), priority high to low:
//   1 accepted rx_rst=1 -> LISTEN.
//   2 accepted ack=1, syn=0, rx_ack_num == ISS+1 -> ESTABLISHED (wins over a same-cycle timeout).
//   3 accepted syn=1, ack=0, rx_seq == IRS (client retransmit) -> SEND_SYNACK, retry unchanged, timer=0.
//   4 timer == SYNACK_TIMEOUT-1: retry == MAX_RETRIES -> LISTEN + abort pulse; else retry+1 -> SEND_SYNACK.
//  ESTABLISHED: accepted rx_rst=1 or rx_fin=1 -> LISTEN (teardown owned by the close controller); all else ignored.
//  Return to LISTEN clears established, timer and retry; mss shows DEFAULT_MSS the cycle LISTEN is entered.
//  Arithmetic: ISS+1 and IRS+1 are modulo 2^32 (0xFFFFFFFF+1 = 0). Timer width = $clog2(SYNACK_TIMEOUT).
//  Latency: SYN accepted in cycle N -> tx_valid in cycle N+1; matching ACK in cycle M -> established in cycle M+1.
// TESTING
//  T1 SYN seq=0x100, mss=1460, isn=0x5000; tx_ready=1 -> SYN-ACK seq=0x5000 ack=0x101 mss=536; ACK ack=0x5001 -> established.
//  T2 SYN mss=0 -> tx_mss=536; SYN mss=400 -> tx_mss=400; SYN mss=536 -> 536.
//  T3 tx_ready held 0 for 20 cycles -> tx_valid and all tx_* fields stable; rx_ready=0 throughout.
//  T4 no ACK, MAX_RETRIES=3 -> 3 retransmits at SYNACK_TIMEOUT spacing, then abort 1 cycle, state LISTEN.
//  T5 seq=0xFFFFFFFF, isn=0xFFFFFFFF -> tx_ack_num=0; ACK ack=0 accepted; ACK ack=5 dropped.
//  T6 valid ACK on timeout cycle -> ESTABLISHED, no retransmit; rst asserted in SEND_SYNACK -> tx_valid 0 next edge.

Source files
------------

// File: rtl/tcp_server_conn_ctrl.sv
// Server-side passive-open TCP connection controller: LISTEN -> SYN-ACK -> ESTABLISHED,
// with MSS negotiation, SYN-ACK retransmission on timeout and abort after the retry budget.
module tcp_server_conn_ctrl #(
  parameter int SYNACK_TIMEOUT = 1000,
  parameter int MAX_RETRIES    = 3,
  parameter int DEFAULT_MSS    = 536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] isn,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        rx_syn,
  input  logic        rx_ack,
  input  logic        rx_fin,
  input  logic        rx_rst,
  input  logic [31:0] rx_seq,
  input  logic [31:0] rx_ack_num,
  input  logic [15:0] rx_mss,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_syn,
  output logic        tx_ack,
  output logic [31:0] tx_seq,
  output logic [31:0] tx_ack_num,
  output logic [15:0] tx_mss,
  output logic [15:0] mss,
  output logic        established,
  output logic        abort,
  output logic [1:0]  state
);

  localparam int TW = (SYNACK_TIMEOUT > 1) ? $clog2(SYNACK_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SYNACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [15:0]   MSS_DEF    = 16'(DEFAULT_MSS);

  typedef enum logic [1:0] {
    LISTEN      = 2'd0,
    SEND_SYNACK = 2'd1,
    WAIT_ACK    = 2'd2,
    ESTABLISHED = 2'd3
  } state_t;

  state_t          state_r, state_n;
  logic [31:0]     iss_r, irs_r;
  logic [TW-1:0]   timer_r;
  logic [RW-1:0]   retry_r;
  logic [15:0]     mss_r, mss_n;
  logic [31:0]     tx_seq_r, tx_ack_num_r;
  logic [15:0]     tx_mss_r;
  logic            tx_valid_r, established_r, abort_r, rx_ready_r;
  logic            accept, latch_syn, retry_inc, abort_n;

  assign accept = rx_valid & rx_ready_r;

  // MSS offered by the peer is honoured only when it is present and below our ceiling
  always_comb begin
    if ((rx_mss < MSS_DEF) && (rx_mss != 16'd0)) begin
      mss_n = rx_mss;
    end else begin
      mss_n = MSS_DEF;
    end
  end

  // Next-state decode; WAIT_ACK branches are ordered by event priority
  always_comb begin
    state_n   = state_r;
    latch_syn = 1'b0;
    retry_inc = 1'b0;
    abort_n   = 1'b0;
    case (state_r)
      LISTEN: begin
        if (accept && rx_syn && !rx_ack && !rx_rst) begin
          state_n   = SEND_SYNACK;
          latch_syn = 1'b1;
        end else begin
          state_n = LISTEN;
        end
      end
      SEND_SYNACK: begin
        if (tx_valid_r && tx_ready) begin
          state_n = WAIT_ACK;
        end else begin
          state_n = SEND_SYNACK;
        end
      end
      WAIT_ACK: begin
        if (accept && rx_rst) begin
          state_n = LISTEN;
        end else if (accept && rx_ack && !rx_syn && (rx_ack_num == iss_r + 32'd1)) begin
          state_n = ESTABLISHED;
        end else if (accept && rx_syn && !rx_ack && (rx_seq == irs_r)) begin
          state_n = SEND_SYNACK;
        end else if (timer_r == TIMER_LAST) begin
          if (retry_r == RETRY_MAX) begin
            state_n = LISTEN;
            abort_n = 1'b1;
          end else begin
            state_n   = SEND_SYNACK;
            retry_inc = 1'b1;
          end
        end else begin
          state_n = WAIT_ACK;
        end
      end
      ESTABLISHED: begin
        if (accept && (rx_rst || rx_fin)) begin
          state_n = LISTEN;
        end else begin
          state_n = ESTABLISHED;
        end
      end
      default: begin
        state_n = LISTEN;
      end
    endcase
  end

  // State, handshake context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= LISTEN;
      iss_r         <= 32'd0;
      irs_r         <= 32'd0;
      timer_r       <= '0;
      retry_r       <= '0;
      mss_r         <= MSS_DEF;
      tx_seq_r      <= 32'd0;
      tx_ack_num_r  <= 32'd0;
      tx_mss_r      <= 16'd0;
      tx_valid_r    <= 1'b0;
      established_r <= 1'b0;
      abort_r       <= 1'b0;
      rx_ready_r    <= 1'b1;
    end else begin
      state_r       <= state_n;
      tx_valid_r    <= (state_n == SEND_SYNACK);
      established_r <= (state_n == ESTABLISHED);
      abort_r       <= abort_n;
      rx_ready_r    <= (state_n != SEND_SYNACK);
      timer_r       <= ((state_r == WAIT_ACK) && (state_n == WAIT_ACK)) ? timer_r + 1'b1 : '0;
      if (latch_syn) begin
        irs_r        <= rx_seq;
        iss_r        <= isn;
        mss_r        <= mss_n;
        retry_r      <= '0;
        tx_seq_r     <= isn;
        tx_ack_num_r <= rx_seq + 32'd1;
        tx_mss_r     <= mss_n;
      end else if (state_n == LISTEN) begin
        mss_r   <= MSS_DEF;
        retry_r <= '0;
      end else if (retry_inc) begin
        retry_r <= retry_r + 1'b1;
      end else begin
        retry_r <= retry_r;
      end
    end
  end

  assign rx_ready    = rx_ready_r;
  assign tx_valid    = tx_valid_r;
  assign tx_syn      = tx_valid_r;
  assign tx_ack      = tx_valid_r;
  assign tx_seq      = tx_seq_r;
  assign tx_ack_num  = tx_ack_num_r;
  assign tx_mss      = tx_mss_r;
  assign mss         = mss_r;
  assign established = established_r;
  assign abort       = abort_r;
  assign state       = state_r;

endmodule

// File: tb/tb_tcp_server_conn_ctrl.sv
// Scoreboard bench for tcp_server_conn_ctrl: expected SYN-ACK requests are queued when a SYN
// is driven and compared when the TX handshake completes.
module tb_tcp_server_conn_ctrl;
  localparam int TO = 1000;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] isn = 32'd0, rx_seq = 32'd0, rx_ack_num = 32'd0;
  logic rx_valid = 1'b0, rx_syn = 1'b0, rx_ack = 1'b0, rx_fin = 1'b0, rx_rst = 1'b0;
  logic [15:0] rx_mss = 16'd0;
  logic tx_ready = 1'b0;
  logic rx_ready, tx_valid, tx_syn, tx_ack, established, abort;
  logic [31:0] tx_seq, tx_ack_num;
  logic [15:0] tx_mss, mss;
  logic [1:0] state;

  int checks = 0, errors = 0, cyc = 0;
  logic [81:0] sb[$];

  tcp_server_conn_ctrl #(.SYNACK_TIMEOUT(TO), .MAX_RETRIES(3), .DEFAULT_MSS(536)) dut (
    .clk(clk), .rst(rst), .isn(isn), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_fin(rx_fin), .rx_rst(rx_rst), .rx_seq(rx_seq),
    .rx_ack_num(rx_ack_num), .rx_mss(rx_mss), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_syn(tx_syn), .tx_ack(tx_ack), .tx_seq(tx_seq), .tx_ack_num(tx_ack_num),
    .tx_mss(tx_mss), .mss(mss), .established(established), .abort(abort), .state(state));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_seg(input logic syn, input logic ack, input logic fin, input logic rs,
                          input logic [31:0] seq, input logic [31:0] an, input logic [15:0] m);
    rx_valid = 1'b1; rx_syn = syn; rx_ack = ack; rx_fin = fin; rx_rst = rs;
    rx_seq = seq; rx_ack_num = an; rx_mss = m;
    step();
    rx_valid = 1'b0; rx_syn = 1'b0; rx_ack = 1'b0; rx_fin = 1'b0; rx_rst = 1'b0;
  endtask

  task automatic wait_tx(input int bound, output bit got, output logic [81:0] obs, output int at);
    got = 1'b0; obs = '0; at = 0;
    for (int i = 0; i < bound && !got; i++) begin
      if (tx_valid && tx_ready) begin
        got = 1'b1; at = cyc;
        obs = {tx_syn, tx_ack, tx_seq, tx_ack_num, tx_mss};
      end
      step();
    end
  endtask

  task automatic pop_exp(output logic [81:0] e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = {82{1'bx}};
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    checks++;
    if ({state, tx_valid, established, abort, rx_ready} !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_ctrl got st=%0d v=%b e=%b a=%b r=%b", state, tx_valid, established, abort, rx_ready);
    end
    checks++;
    if ({tx_seq, tx_ack_num, tx_mss, mss} !== {32'd0, 32'd0, 16'd0, 16'd536}) begin
      errors++; $display("FAIL reset_fields got seq=%h ack=%h txmss=%0d mss=%0d", tx_seq, tx_ack_num, tx_mss, mss);
    end
  endtask

  task automatic test_handshake();
    bit got; logic [81:0] o, e; int at;
    tx_ready = 1'b1; isn = 32'h5000;
    sb.push_back({2'b11, 32'h5000, 32'h101, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 16'd1460);
    isn = 32'h1234;
    checks++;
    if ({tx_valid, state, rx_ready} !== {1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL syn_latency got v=%b st=%0d r=%b want 1 1 0", tx_valid, state, rx_ready);
    end
    wait_tx(50, got, o, at); pop_exp(e);
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL t1_synack got %h want %h", o, e); end
    checks++;
    if ({state, tx_valid, mss} !== {2'd2, 1'b0, 16'd536}) begin
      errors++; $display("FAIL t1_wait got st=%0d v=%b mss=%0d", state, tx_valid, mss);
    end
    send_seg(1'b0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h5001, 16'd0);
    checks++;
    if ({state, established} !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL t1_established got st=%0d e=%b", state, established);
    end
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 16'd0);
    checks++;
    if ({state, tx_valid} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL est_ignore got st=%0d v=%b", state, tx_valid);
    end
    send_seg(1'b0, 1'b1, 1'b1, 1'b0, 32'h101, 32'h5001, 16'd0);
    checks++;
    if ({state, established, mss} !== {2'd0, 1'b0, 16'd536}) begin
      errors++; $display("FAIL fin_to_listen got st=%0d e=%b mss=%0d", state, established, mss);
    end
  endtask

  task automatic test_mss();
    bit got; logic [81:0] o, e; int at;
    logic [15:0] offer [5] = '{16'd0, 16'd400, 16'd536, 16'd537, 16'd1};
    logic [15:0] want  [5] = '{16'd536, 16'd400, 16'd536, 16'd536, 16'd1};
    tx_ready = 1'b1; isn = 32'h20;
    for (int k = 0; k < 5; k++) begin
      sb.push_back({2'b11, 32'h20, 32'h11 + 32'(k), want[k]});
      send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h10 + 32'(k), 32'd0, offer[k]);
      wait_tx(50, got, o, at); pop_exp(e);
      checks++;
      if (!got || o !== e) begin errors++; $display("FAIL mss_%0d got %h want %h", k, o, e); end
      checks++;
      if (mss !== want[k]) begin errors++; $display("FAIL mss_out_%0d got %0d want %0d", k, mss, want[k]); end
      send_seg(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 16'd0);
      checks++;
      if ({state, mss} !== {2'd0, 16'd536}) begin
        errors++; $display("FAIL rst_wait_%0d got st=%0d mss=%0d", k, state, mss);
      end
    end
  endtask

  task automatic test_backpressure();
    bit got, bad; logic [81:0] o, e; int at;
    tx_ready = 1'b0; isn = 32'h7777; bad = 1'b0;
    sb.push_back({2'b11, 32'h7777, 32'h2001, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 32'd0, 16'd1000);
    for (int i = 0; i < 20; i++) begin
      isn = $urandom; rx_valid = 1'b1; rx_syn = 1'b1; rx_seq = $urandom;
      if ({tx_valid, tx_syn, tx_ack, tx_seq, tx_ack_num, tx_mss, rx_ready} !==
          {3'b111, 32'h7777, 32'h2001, 16'd536, 1'b0}) bad = 1'b1;
      step();
    end
    rx_valid = 1'b0; rx_syn = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL backpressure_stable got unstable want stable"); end
    tx_ready = 1'b1;
    wait_tx(5, got, o, at); pop_exp(e);
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL backpressure_synack got %h want %h", o, e); end
    send_seg(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 16'd0);
  endtask

  task automatic test_client_retx();
    bit got; logic [81:0] o, e; int at;
    tx_ready = 1'b1; isn = 32'hA000;
    sb.push_back({2'b11, 32'hA000, 32'h401, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'd0, 16'd1200);
    wait_tx(50, got, o, at); pop_exp(e);
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h999, 32'd0, 16'd0);
    checks++;
    if ({state, tx_valid} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL retx_mismatch_drop got st=%0d v=%b", state, tx_valid);
    end
    sb.push_back({2'b11, 32'hA000, 32'h401, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'd0, 16'd0);
    wait_tx(50, got, o, at); pop_exp(e);
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL client_retx got %h want %h", o, e); end
    send_seg(1'b1, 1'b1, 1'b0, 1'b0, 32'h401, 32'hA001, 16'd0);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL synack_in_wait got st=%0d want 2", state); end
    send_seg(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 16'd0);
  endtask

  task automatic test_retries();
    bit got; logic [81:0] o, e; int at, prev;
    tx_ready = 1'b1; isn = 32'h9000; prev = 0;
    for (int k = 0; k < 4; k++) sb.push_back({2'b11, 32'h9000, 32'h301, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'd0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      wait_tx(TO + 50, got, o, at); pop_exp(e);
      checks++;
      if (!got || o !== e) begin errors++; $display("FAIL retx_%0d got %h want %h", k, o, e); end
      if (k > 0) begin
        checks++;
        if (at - prev !== TO + 1) begin
          errors++; $display("FAIL retx_spacing_%0d got %0d want %0d", k, at - prev, TO + 1);
        end
      end
      prev = at;
    end
    for (int i = 0; i < TO + 50 && !abort; i++) step();
    checks++;
    if (!abort || cyc - prev !== TO + 1 || state !== 2'd0) begin
      errors++; $display("FAIL abort_timing got a=%b dt=%0d st=%0d want 1 %0d 0", abort, cyc - prev, state, TO + 1);
    end
    step();
    checks++;
    if ({abort, state, tx_valid} !== {1'b0, 2'd0, 1'b0}) begin
      errors++; $display("FAIL abort_pulse got a=%b st=%0d v=%b", abort, state, tx_valid);
    end
  endtask

  task automatic test_wrap();
    bit got; logic [81:0] o, e; int at;
    tx_ready = 1'b1; isn = 32'hFFFFFFFF;
    sb.push_back({2'b11, 32'hFFFFFFFF, 32'h0, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0, 16'd0);
    wait_tx(50, got, o, at); pop_exp(e);
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL wrap_synack got %h want %h", o, e); end
    send_seg(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd5, 16'd0);
    checks++;
    if ({state, established} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL wrap_bad_ack got st=%0d e=%b", state, established);
    end
    send_seg(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 16'd0);
    checks++;
    if ({state, established} !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL wrap_ack got st=%0d e=%b", state, established);
    end
    send_seg(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 16'd0);
  endtask

  task automatic test_timeout_race();
    bit got, bad; logic [81:0] o, e; int at;
    tx_ready = 1'b1; isn = 32'h40; bad = 1'b0;
    sb.push_back({2'b11, 32'h40, 32'h81, 16'd536});
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'd0, 16'd0);
    wait_tx(50, got, o, at); pop_exp(e);
    repeat (TO - 1) step();
    send_seg(1'b0, 1'b1, 1'b0, 1'b0, 32'h81, 32'h41, 16'd0);
    checks++;
    if ({state, established, tx_valid} !== {2'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL race_ack got st=%0d e=%b v=%b", state, established, tx_valid);
    end
    for (int i = 0; i < 5; i++) begin
      if (tx_valid !== 1'b0 || state !== 2'd3) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL race_no_retx got retransmit want none"); end
    send_seg(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 16'd0);
    tx_ready = 1'b0; isn = 32'h55;
    send_seg(1'b1, 1'b0, 1'b0, 1'b0, 32'h66, 32'd0, 16'd0);
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({tx_valid, state, tx_seq, established} !== {1'b0, 2'd0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL midreset got v=%b st=%0d seq=%h", tx_valid, state, tx_seq);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_mss();
    test_backpressure();
    test_client_retx();
    test_retries();
    test_wrap();
    test_timeout_race();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
